// File: rtl/cmd_sequencer.sv
// Command FIFO feeding an IDLE/BURST sequencer that drives load/increment strobes into a
// downstream 3-bit counter and refuses any increment that would wrap it.
// Optional drop counter output is enabled by defining CMD_SEQ_DROP_CNT_EN.
module cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_data,
    output logic       cmd_ready,
    output logic       ld,
    output logic       inc,
    output logic [2:0] data_in,
    input  logic       err_clr,
    output logic       ovf_err,
    output logic       busy
`ifdef CMD_SEQ_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_INC   = 2'b10,
        OP_INC_N = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [4:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [2:0]    remaining_q, remaining_d;
    logic [2:0]    shadow_q, shadow_d;
    logic [2:0]    data_in_q, data_in_d;
    logic          ld_q, ld_d;
    logic          inc_q, inc_d;
    logic          ovf_q, ovf_d;

    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    op_e           head_op_s;
    logic [2:0]    head_data_s;

    assign cmd_ready   = (count_q != FULL_CNT);
    assign push_s      = cmd_valid && cmd_ready;
    assign head_op_s   = op_e'(mem_q[rd_ptr_q][4:3]);
    assign head_data_s = mem_q[rd_ptr_q][2:0];

    assign ld      = ld_q;
    assign inc     = inc_q;
    assign data_in = data_in_q;
    assign ovf_err = ovf_q;
    assign busy    = (count_q != ZERO_CNT) || (state_q != ST_IDLE);

    // FIFO storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {cmd_op, cmd_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer: decodes the FIFO head in IDLE, runs increment bursts in BURST.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shadow_d    = shadow_q;
        data_in_d   = data_in_q;
        ld_d        = 1'b0;
        inc_d       = 1'b0;
        pop_s       = 1'b0;
        ovf_set_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != ZERO_CNT) begin
                    pop_s = 1'b1;
                    case (head_op_s)
                        OP_NOP: begin
                            ld_d = 1'b0;
                        end
                        OP_LOAD: begin
                            ld_d      = 1'b1;
                            data_in_d = head_data_s;
                            shadow_d  = head_data_s;
                        end
                        OP_INC: begin
                            if (shadow_q != 3'd7) begin
                                inc_d    = 1'b1;
                                shadow_d = shadow_q + 3'd1;
                            end else begin
                                ovf_set_s = 1'b1;
                            end
                        end
                        OP_INC_N: begin
                            if (head_data_s != 3'd0) begin
                                state_d     = ST_BURST;
                                remaining_d = head_data_s;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: begin
                            ld_d = 1'b0;
                        end
                    endcase
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_BURST: begin
                // remaining is never zero here: INC_N 0 never enters the burst.
                if (shadow_q != 3'd7) begin
                    inc_d       = 1'b1;
                    shadow_d    = shadow_q + 3'd1;
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    ovf_set_s   = 1'b1;
                    remaining_d = 3'd0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_comb begin
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State register for FIFO, sequencer and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 5'd0;
            end
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= ZERO_CNT;
            state_q     <= ST_IDLE;
            remaining_q <= 3'd0;
            shadow_q    <= 3'd0;
            data_in_q   <= 3'd0;
            ld_q        <= 1'b0;
            inc_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shadow_q    <= shadow_d;
            data_in_q   <= data_in_d;
            ld_q        <= ld_d;
            inc_q       <= inc_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef CMD_SEQ_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt = drop_cnt_q;

    // Saturating count of refused increments; a refusal in the clearing cycle counts as 1.
    always_comb begin
        if (ovf_set_s) begin
            if (err_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'd255) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (err_clr) begin
            drop_cnt_d = 8'd0;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule
